// File: rtl/image_reader.sv
// Streams one stored frame out of a synchronous-read pixel RAM as a raster-ordered valid/ready
// pixel stream with eol/eof flags. Define IMAGE_READER_ZERO_PAD_EN to wrap the image in a zero border.
module image_reader #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_eol,
   output logic              out_eof
);

`ifdef IMAGE_READER_ZERO_PAD_EN
   localparam int PW = IMG_W + 2;
   localparam int PH = IMG_H + 2;
`else
   localparam int PW = IMG_W;
   localparam int PH = IMG_H;
`endif
   localparam int CW = $clog2(PW);
   localparam int RW = $clog2(PH);
   localparam int WW = DATA_W + 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              pend_q, pend_d;
   logic              pend_eol_q, pend_eol_d;
   logic              pend_eof_q, pend_eof_d;
   logic              h0_v_q, h0_v_d, h1_v_q, h1_v_d;
   logic [WW-1:0]     h0_q, h0_d, h1_q, h1_d;
`ifdef IMAGE_READER_ZERO_PAD_EN
   logic              pend_zero_q, pend_zero_d;
`endif

   logic          last_col, last_row, interior, issue, hs, head_v;
   logic [1:0]    tokens;
   logic [WW-1:0] rd_word, head;

   // Position decode, returning-read word and read-issue credit
   always_comb begin
      last_col = (col_q == CW'(PW - 1));
      last_row = (row_q == RW'(PH - 1));
`ifdef IMAGE_READER_ZERO_PAD_EN
      interior = (row_q != {RW{1'b0}}) && !last_row && (col_q != {CW{1'b0}}) && !last_col;
      rd_word  = {pend_eof_q, pend_eol_q, (pend_zero_q ? {DATA_W{1'b0}} : mem_rdata)};
`else
      interior = 1'b1;
      rd_word  = {pend_eof_q, pend_eol_q, mem_rdata};
`endif
      head_v = h0_v_q | pend_q;
      if (h0_v_q) begin
         head = h0_q;
      end else if (pend_q) begin
         head = rd_word;
      end else begin
         head = {WW{1'b0}};
      end
      hs     = head_v & out_ready;
      // Outstanding read plus held pixels, less the one leaving this cycle, must stay below two
      tokens = {1'b0, pend_q} + {1'b0, h0_v_q} + {1'b0, h1_v_q};
      issue  = (state_q == S_RUN) && (tokens < (2'd2 + {1'b0, hs}));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
            else       state_d = S_IDLE;
         end
         S_RUN: begin
            if (issue && last_col && last_row) state_d = S_DRAIN;
            else                               state_d = S_RUN;
         end
         S_DRAIN: begin
            if (hs && head[WW-1]) state_d = S_DONE;
            else                  state_d = S_DRAIN;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      mem_en    = issue & interior;
      mem_addr  = addr_q;
      out_valid = head_v;
      out_data  = head[DATA_W-1:0];
      out_eol   = head[DATA_W];
      out_eof   = head[DATA_W+1];
   end

   // Raster counters and linear read address
   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      addr_d     = addr_q;
      pend_d     = issue;
      pend_eol_d = issue & last_col;
      pend_eof_d = issue & last_col & last_row;
`ifdef IMAGE_READER_ZERO_PAD_EN
      pend_zero_d = issue & ~interior;
`endif
      if (state_q == S_IDLE) begin
         col_d  = {CW{1'b0}};
         row_d  = {RW{1'b0}};
         addr_d = {ADDR_W{1'b0}};
      end else if (issue) begin
         if (last_col) begin
            col_d = {CW{1'b0}};
            if (last_row) row_d = {RW{1'b0}};
            else          row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         if (interior) addr_d = addr_q + ADDR_W'(1);
         else          addr_d = addr_q;
      end else begin
         addr_d = addr_q;
      end
   end

   // Output holding register (h0) and skid entry (h1) catching RAM data that cannot leave yet
   always_comb begin
      h0_v_d = h0_v_q;
      h0_d   = h0_q;
      h1_v_d = h1_v_q;
      h1_d   = h1_q;
      if (!h0_v_q) begin
         if (pend_q && !out_ready) begin
            h0_v_d = 1'b1;
            h0_d   = rd_word;
         end else begin
            h0_v_d = 1'b0;
         end
      end else if (!h1_v_q) begin
         if (out_ready) begin
            h0_v_d = pend_q;
            if (pend_q) h0_d = rd_word;
            else        h0_d = h0_q;
         end else if (pend_q) begin
            h1_v_d = 1'b1;
            h1_d   = rd_word;
         end else begin
            h1_v_d = 1'b0;
         end
      end else begin
         if (out_ready) begin
            h0_d   = h1_q;
            h1_v_d = 1'b0;
         end else begin
            h1_v_d = 1'b1;
         end
      end
   end

   // Datapath registers; reset discards any in-flight read
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q      <= {CW{1'b0}};
         row_q      <= {RW{1'b0}};
         addr_q     <= {ADDR_W{1'b0}};
         pend_q     <= 1'b0;
         pend_eol_q <= 1'b0;
         pend_eof_q <= 1'b0;
         h0_v_q     <= 1'b0;
         h1_v_q     <= 1'b0;
         h0_q       <= {WW{1'b0}};
         h1_q       <= {WW{1'b0}};
`ifdef IMAGE_READER_ZERO_PAD_EN
         pend_zero_q <= 1'b0;
`endif
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         addr_q     <= addr_d;
         pend_q     <= pend_d;
         pend_eol_q <= pend_eol_d;
         pend_eof_q <= pend_eof_d;
         h0_v_q     <= h0_v_d;
         h1_v_q     <= h1_v_d;
         h0_q       <= h0_d;
         h1_q       <= h1_d;
`ifdef IMAGE_READER_ZERO_PAD_EN
         pend_zero_q <= pend_zero_d;
`endif
      end
   end

endmodule

// File: tb/tb_image_reader.sv
// Self-checking bench for image_reader (4x3 image); expected pixels are queued at start and
// popped on each handshake. Expectations follow IMAGE_READER_ZERO_PAD_EN when defined.
module tb_image_reader;
   localparam int W = 4;
   localparam int H = 3;
`ifdef IMAGE_READER_ZERO_PAD_EN
   localparam int PW = W + 2;
   localparam int PH = H + 2;
   localparam logic FIRST_EN = 1'b0;
`else
   localparam int PW = W;
   localparam int PH = H;
   localparam logic FIRST_EN = 1'b1;
`endif
   localparam int NPIX = PW * PH;
   localparam int NRD  = W * H;

   logic       clk, rst, start, busy, done, mem_en;
   logic [9:0] mem_addr;
   logic [7:0] mem_rdata, out_data;
   logic       out_valid, out_ready, out_eol, out_eof;
   logic [7:0] ram [0:1023];

   int         checks = 0;
   int         errors = 0;
   logic [9:0] exp_q[$];
   int         pix_cnt = 0, done_cnt = 0, mem_en_cnt = 0;
   bit         hs_eof_now = 1'b0, hs_eof_prev = 1'b0, stall_prev = 1'b0;
   logic [9:0] held_word = 10'd0, mon_word, mon_exp;

   image_reader #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_eol(out_eol), .out_eof(out_eof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

   // Scoreboard and stall-stability monitor, sampled on the falling edge
   always @(negedge clk) begin
      mon_word = {out_eof, out_eol, out_data};
      if (!rst) begin
         if (stall_prev) begin
            checks++;
            if (!out_valid || mon_word !== held_word) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b word=%0h, required valid=1 word=%0h", out_valid, mon_word, held_word);
            end
         end
         if (out_valid && out_ready) begin
            pix_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pixel_extra: got word=%0h, required no pixel", mon_word);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_word !== mon_exp) begin
                  errors++;
                  $display("FAIL pixel: got {eof,eol,data}=%0h, required %0h", mon_word, mon_exp);
               end
            end
         end
         stall_prev  = out_valid && !out_ready;
         held_word   = mon_word;
         hs_eof_prev = hs_eof_now;
         hs_eof_now  = out_valid && out_ready && out_eof;
         if (mem_en) mem_en_cnt++;
         if (done) done_cnt++;
      end else begin
         stall_prev = 1'b0;
         hs_eof_now = 1'b0;
      end
   end

   task automatic push_frame();
      for (int r = 0; r < PH; r++) begin
         for (int c = 0; c < PW; c++) begin
            logic [7:0] d;
            logic eol, eof;
`ifdef IMAGE_READER_ZERO_PAD_EN
            if (r >= 1 && r <= H && c >= 1 && c <= W) d = 8'((r - 1) * W + (c - 1) + 1);
            else d = 8'd0;
`else
            d = 8'(r * W + c + 1);
`endif
            eol = (c == PW - 1);
            eof = eol && (r == PH - 1);
            exp_q.push_back({eof, eol, d});
         end
      end
   endtask

   task automatic start_frame();
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_before_start: busy=%0b, required 0", busy); end
      push_frame();
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || mem_en !== FIRST_EN || mem_addr !== 10'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL after_start: busy=%0b mem_en=%0b addr=%0d valid=%0b, required 1 %0b 0 0", busy, mem_en, mem_addr, out_valid, FIRST_EN);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: valid=%0b, required 1", out_valid); end
      #1;
   endtask

   task automatic drive_frame(input bit rnd, input bit inj, output int n, output bit to);
      bit seen = 1'b0;
      n = 0;
      to = 1'b0;
      while (!seen && !to) begin
         @(posedge clk); #1;
         out_ready = rnd ? (($urandom_range(0, 2)) != 0) : 1'b1;
         start = inj && ((pix_cnt % NPIX) == 4 || hs_eof_now);
         @(negedge clk); #1;
         n++;
         if (done) seen = 1'b1;
         if (n > 500) to = 1'b1;
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, mem_en, out_valid, out_eol, out_eof} !== 6'b0 || mem_addr !== 10'd0 || out_data !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: flags=%0b addr=%0d data=%0d, required all 0", {busy, done, mem_en, out_valid, out_eol, out_eof}, mem_addr, out_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%0b mem_en=%0b, required 0 0", busy, mem_en); end
   endtask

   task automatic test_basic();
      int bp = pix_cnt, be = mem_en_cnt, bd = done_cnt, n;
      bit to;
      start_frame();
      drive_frame(1'b0, 1'b0, n, to);
      checks++; if (to) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
      checks++; if (n != NPIX) begin errors++; $display("FAIL basic_cycles: done after %0d cycles, required %0d", n, NPIX); end
      checks++; if (!hs_eof_prev) begin errors++; $display("FAIL done_timing: done not one cycle after eof handshake"); end
      checks++; if (pix_cnt - bp != NPIX) begin errors++; $display("FAIL basic_count: got %0d pixels, required %0d", pix_cnt - bp, NPIX); end
      checks++; if (mem_en_cnt - be != NRD) begin errors++; $display("FAIL mem_en_count: got %0d reads, required %0d", mem_en_cnt - be, NRD); end
      checks++; if (done_cnt - bd != 1) begin errors++; $display("FAIL done_count: got %0d, required 1", done_cnt - bd); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL busy_after_done: busy=%0b done=%0b, required 0 0", busy, done); end
   endtask

   task automatic test_backpressure();
      int bp = pix_cnt, be = mem_en_cnt, n;
      bit to;
      start_frame();
      drive_frame(1'b1, 1'b0, n, to);
      checks++; if (to) begin errors++; $display("FAIL bp_timeout: no done within budget"); end
      checks++; if (pix_cnt - bp != NPIX) begin errors++; $display("FAIL bp_count: got %0d pixels, required %0d", pix_cnt - bp, NPIX); end
      checks++; if (mem_en_cnt - be != NRD) begin errors++; $display("FAIL bp_reads: got %0d, required %0d", mem_en_cnt - be, NRD); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing: %0d pixels never arrived, required 0", exp_q.size()); end
   endtask

   task automatic test_start_ignored();
      int bp = pix_cnt, bd = done_cnt, n;
      bit to;
      start_frame();
      drive_frame(1'b0, 1'b1, n, to);
      repeat (3) begin @(posedge clk); #1; @(negedge clk); end
      checks++; if (to) begin errors++; $display("FAIL ign_timeout: no done within budget"); end
      checks++; if (pix_cnt - bp != NPIX) begin errors++; $display("FAIL ign_count: got %0d pixels, required %0d", pix_cnt - bp, NPIX); end
      checks++; if (done_cnt - bd != 1) begin errors++; $display("FAIL ign_done: got %0d done pulses, required 1", done_cnt - bd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_restart: busy=%0b, required 0", busy); end
   endtask

   task automatic test_reset_midframe();
      int bp = pix_cnt, k = 0, n;
      bit to;
      start_frame();
      while (pix_cnt - bp < 5 && k < 100) begin
         @(posedge clk); #1; out_ready = 1'b1; @(negedge clk); #1; k++;
      end
      @(posedge clk); #1;
      rst = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, mem_en, out_valid, out_eol, out_eof} !== 6'b0 || mem_addr !== 10'd0 || out_data !== 8'd0) begin
         errors++;
         $display("FAIL midframe_reset: flags=%0b addr=%0d data=%0d, required all 0", {busy, done, mem_en, out_valid, out_eol, out_eof}, mem_addr, out_data);
      end
      exp_q.delete();
      out_ready = 1'b1;
      bp = pix_cnt;
      start_frame();
      drive_frame(1'b0, 1'b0, n, to);
      checks++; if (to) begin errors++; $display("FAIL rst_timeout: no done within budget"); end
      checks++; if (pix_cnt - bp != NPIX) begin errors++; $display("FAIL rst_count: got %0d pixels, required %0d", pix_cnt - bp, NPIX); end
   endtask

   task automatic test_back_to_back();
      int bp = pix_cnt, n1, n2;
      bit to1, to2;
      start_frame();
      drive_frame(1'b0, 1'b0, n1, to1);
      start_frame();
      drive_frame(1'b0, 1'b0, n2, to2);
      checks++; if (to1 || to2) begin errors++; $display("FAIL b2b_timeout: no done within budget"); end
      checks++; if (n2 != NPIX) begin errors++; $display("FAIL b2b_cycles: second frame done after %0d cycles, required %0d", n2, NPIX); end
      checks++; if (pix_cnt - bp != 2 * NPIX) begin errors++; $display("FAIL b2b_count: got %0d pixels, required %0d", pix_cnt - bp, 2 * NPIX); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: %0d pixels never arrived, required 0", exp_q.size()); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'(i + 1);
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_start_ignored();
      test_reset_midframe();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/image_reader.md
# image_reader

Streams one stored image out of a synchronous-read pixel RAM as a raster-ordered valid/ready pixel stream for the convolution datapath. A single-cycle `start` pulse triggers one full frame, and the frame is marked with end-of-line and end-of-frame flags. The block sits between the frame buffer and the `Convolutor` input. It supplies the pixel stream that the convolver consumes, and sustains one pixel per clock whenever the consumer is ready.

## Interface
- `DATA_W`, 8: pixel width in bits.
- `IMG_W`, 32: image width in pixels (≥2).
- `IMG_H`, 32: image height in pixels (≥2).
- `ADDR_W`, 10: RAM address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one frame; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last pixel handshake.
- `mem_en`  out  1  RAM read enable.
- `mem_addr`  out  ADDR_W  RAM read address.
- `mem_rdata`  in  DATA_W  RAM read data, valid the cycle after `mem_en`.
- `out_data`  out  DATA_W  pixel.
- `out_valid`  out  1  pixel valid.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_eol`  out  1  qualifies the last pixel of a row.
- `out_eof`  out  1  qualifies the last pixel of the frame (`out_eol` is also high).

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN issues reads in raster order. After the last address is issued, RUN → DRAIN.
  - DRAIN → DONE when the last pixel handshakes.
  - DONE → IDLE unconditionally after 1 cycle, with `done`=1.
- Address generation:
  - `mem_addr` = row·IMG_W + col, implemented as a linear increment.
  - Column and row counters wrap at IMG_W−1 and IMG_H−1.
  - `eol`/`eof` are computed from the counters and pipelined alongside the read.
- Buffering:
  - One output register plus a one-entry skid buffer absorbs the one-cycle RAM latency.
  - A read is issued only when the number of outstanding reads plus held pixels is less than 2. No read data is ever dropped.
- Backpressure: while `out_ready`=0, `out_valid`, `out_data`, `out_eol` and `out_eof` hold stable.
- `start` while `busy`: ignored, with no restart and no queueing. `start` in DONE: ignored.
- `rst` mid-frame: the next cycle is IDLE with all outputs at their reset values, and the in-flight read is discarded.
- Reset values: `busy`, `done`, `mem_en`, `out_valid`, `out_eol`, `out_eof` = 0; `mem_addr`, `out_data` = 0.

## Timing
- `start` sampled high at edge E0 in IDLE:
  - After E0: `busy`=1, `mem_en`=1, `mem_addr`=0.
  - After E1: `out_valid`=1 with pixel 0, so the first pixel appears 2 cycles after `start` is sampled.
- With `out_ready` held at 1, one pixel transfers per cycle with no bubbles. A W×H frame takes W·H cycles from the first valid.
- The last handshake occurs at edge En. After En, `out_valid`=0 and `done`=1 for one cycle. After En+1, `busy`=0 and the block is IDLE. A new `start` is accepted from that cycle on.
- `out_ready` deasserted for N cycles: the stream stalls exactly N cycles, and order and flags are preserved.

## Configuration
- `IMAGE_READER_ZERO_PAD_EN` defined:
  - The stream is (IMG_W+2)×(IMG_H+2), with a 1-pixel border of zero pixels around the image for 3×3 convolution.
  - Border pixels are generated internally with `mem_en`=0 and no RAM access.
  - Interior pixel (r,c) reads address (r−1)·IMG_W+(c−1).
  - `eol`/`eof` mark the padded geometry.
  - Latency to the first valid is still 2 cycles; pixel 0 is a zero.
- Undefined: no border; the stream is IMG_W×IMG_H, and the padding logic is not compiled.

## Test plan
1. IMG_W=4, IMG_H=3, RAM[i]=i+1, `out_ready`=1, pulse `start`:
   - Pixels 1..12 arrive on consecutive cycles, with first valid 2 cycles after `start`.
   - `out_eol` on 4, 8 and 12; `out_eof` only on 12.
   - `done` pulses 1 cycle after 12; `busy`=0 the cycle after that.
2. Same setup, `out_ready` toggled 1,0,0,1,… pseudo-randomly: the sequence is still 1..12 with no loss or duplicate, and data and flags stay stable while stalled.
3. `start` pulsed again mid-frame (pixel 5) and during `done`: ignored. Exactly 12 pixels and one `done` result.
4. `rst` asserted at pixel 6 while a read is outstanding:
   - Next cycle: all outputs 0 and state IDLE.
   - A fresh `start` then yields 1..12 from address 0.
5. `IMAGE_READER_ZERO_PAD_EN` defined, IMG_W=4, IMG_H=3:
   - 30 pixels: row 0 is six zeros; row 1 is 0,1,2,3,4,0; rows 2–3 follow the same pattern; row 4 is six zeros.
   - `mem_en` is high exactly 12 times; `out_eof` is on pixel 30.
6. Back-to-back frames with `start` asserted the first cycle `busy`=0: the second frame's first valid comes 2 cycles later with identical content.
